// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with qualifying valid, overlap mode
// and a saturating match counter with synchronous clear.
module seq_detect_param #(
  parameter int unsigned          PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = 5'b10010,
  parameter bit                   REPEAT  = 1'b1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             cnt_clr,
  output logic             data_out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned        FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FULL   = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0]  LAST   = FILL_W'(PAT_LEN - 1);

  // Only the newest PAT_LEN-1 bits are stored: the oldest bit of a
  // PAT_LEN-bit history is shifted out before it could ever be compared.
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAT_LEN-1:0] window;
  logic               match;

  // Next-state: history shift, fill tracking, match pulse and counter.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    window = {hist_q, data_in};
    match  = data_valid && (fill_q >= LAST) && (window == PATTERN);
    out_d  = match;
    cnt_d  = cnt_q;

    if (data_valid) begin
      hist_d = window[PAT_LEN-2:0];
      if (match && !REPEAT) begin
        fill_d = '0;
      end else if (fill_q != FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (match) begin
      if (cnt_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out  = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  localparam int R1 = 0;  // default pattern, overlapping
  localparam int R0 = 1;  // default pattern, non-overlapping
  localparam int C2 = 2;  // 2-bit counter
  localparam int P1 = 3;  // PAT_LEN=2 11, overlapping
  localparam int P0 = 4;  // PAT_LEN=2 11, non-overlapping
  localparam int Z2 = 5;  // PAT_LEN=2 00

  logic clk, rst_n, data_in, data_valid, cnt_clr;
  logic       o_r1, o_r0, o_c2, o_p1, o_p0, o_z2;
  logic [7:0] c_r1, c_r0, c_p1, c_p0, c_z2;
  logic [1:0] c_c2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    logic       o;
    int         c;
    string      nm;
  } exp_t;
  exp_t q[$];

  seq_detect_param u_r1 (.clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
                         .cnt_clr(cnt_clr), .data_out(o_r1), .match_cnt(c_r1));
  seq_detect_param #(.REPEAT(1'b0)) u_r0 (.clk(clk), .rst_n(rst_n), .data_in(data_in),
                         .data_valid(data_valid), .cnt_clr(cnt_clr), .data_out(o_r0), .match_cnt(c_r0));
  seq_detect_param #(.CNT_W(2)) u_c2 (.clk(clk), .rst_n(rst_n), .data_in(data_in),
                         .data_valid(data_valid), .cnt_clr(cnt_clr), .data_out(o_c2), .match_cnt(c_c2));
  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .REPEAT(1'b1)) u_p1 (.clk(clk), .rst_n(rst_n),
                         .data_in(data_in), .data_valid(data_valid), .cnt_clr(cnt_clr), .data_out(o_p1), .match_cnt(c_p1));
  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .REPEAT(1'b0)) u_p0 (.clk(clk), .rst_n(rst_n),
                         .data_in(data_in), .data_valid(data_valid), .cnt_clr(cnt_clr), .data_out(o_p0), .match_cnt(c_p0));
  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b00), .REPEAT(1'b1)) u_z2 (.clk(clk), .rst_n(rst_n),
                         .data_in(data_in), .data_valid(data_valid), .cnt_clr(cnt_clr), .data_out(o_z2), .match_cnt(c_z2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] obs(input int d);
    case (d)
      R1:      return {o_r1, c_r1};
      R0:      return {o_r0, c_r0};
      C2:      return {o_c2, 6'b0, c_c2};
      P1:      return {o_p1, c_p1};
      P0:      return {o_p0, c_p0};
      default: return {o_z2, c_z2};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got out=%0b cnt=%0d, expected out=%0b cnt=%0d",
               nm, act[8], act[7:0], expv[8], expv[7:0]);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare all pending expectations.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, obs(e.dut), {e.o, 8'(e.c)});
    end
  end

  task automatic drive(input logic v, input logic d, input logic clr);
    @(negedge clk);
    data_valid = v;
    data_in    = d;
    cnt_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input int dut, input logic o, input int c, input string nm);
    exp_t e;
    e.dut = dut; e.o = o; e.c = c; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; data_valid = 1'b0; data_in = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] s1       = 8'b1001_0010;  // MSB first: 1,0,0,1,0,0,1,0
  logic [7:0] r1_out   = 8'b0000_1001;
  logic [7:0] r0_out   = 8'b0000_1000;
  int         r1_cnt[8] = '{0, 0, 0, 0, 1, 1, 1, 2};
  int         r0_cnt[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic [4:0] s3       = 5'b10010;
  logic [3:0] s5a      = 4'b1001;
  logic [5:0] s5b      = 6'b010010;
  logic [5:0] s5b_out  = 6'b000001;
  int         c2_cnt[20] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 1};
  logic [3:0] p1_out   = 4'b0111;
  int         p1_cnt[4] = '{0, 1, 2, 3};
  logic [3:0] p0_out   = 4'b0101;
  int         p0_cnt[4] = '{0, 1, 1, 2};

  initial begin
    rst_n = 1'b0; data_in = 1'b0; data_valid = 1'b0; cnt_clr = 1'b0;
    #12;
    for (int d = 0; d < 6; d++) chk($sformatf("reset_dut%0d", d), obs(d), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tests 1/2: overlapping vs non-overlapping on one stream.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s1[7-i], 1'b0);
      expect_o(R1, r1_out[7-i], r1_cnt[i], $sformatf("t1_rep1_bit%0d", i + 1));
      expect_o(R0, r0_out[7-i], r0_cnt[i], $sformatf("t2_rep0_bit%0d", i + 1));
    end

    // Test 5: partial 1,0,0,1 then asynchronous reset mid-cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s5a[3-i], 1'b0);
      expect_o(R1, 1'b0, 2, $sformatf("t5_pre_bit%0d", i + 1));
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0; data_valid = 1'b0;
    #1;
    chk("t5_async_r1", obs(R1), 9'd0);
    chk("t5_async_r0", obs(R0), 9'd0);
    #14;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, s5b[5-i], 1'b0);
      expect_o(R1, s5b_out[5-i], int'(s5b_out[5-i]), $sformatf("t5_post_bit%0d", i + 1));
    end

    // Test 3: gaps of 3 invalid cycles between bits.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s3[4-i], 1'b0);
      expect_o(R1, (i == 4), (i == 4) ? 1 : 0, $sformatf("t3_bit%0d", i + 1));
      for (int g = 0; g < 3; g++) begin
        drive(1'b0, 1'b0, 1'b0);
        expect_o(R1, 1'b0, (i == 4) ? 1 : 0, $sformatf("t3_gap%0d_%0d", i + 1, g));
      end
    end

    // Test 4: saturation with CNT_W=2, then clear with and without a match.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i % 3) == 0, i == 19);
      expect_o(C2, (i % 3) == 1 && i >= 4, c2_cnt[i], $sformatf("t4_bit%0d", i + 1));
    end
    drive(1'b0, 1'b0, 1'b1);
    expect_o(C2, 1'b0, 0, "t4_clr_alone");

    // Test 6: PAT_LEN=2 with both overlap modes.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      expect_o(P1, p1_out[3-i], p1_cnt[i], $sformatf("t6_rep1_bit%0d", i + 1));
      expect_o(P0, p0_out[3-i], p0_cnt[i], $sformatf("t6_rep0_bit%0d", i + 1));
    end

    // Fill rule: all-zero pattern must not fire on the reset history.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    expect_o(Z2, 1'b0, 0, "t6_zero_first");
    drive(1'b1, 1'b0, 1'b0);
    expect_o(Z2, 1'b1, 1, "t6_zero_second");
    drive(1'b0, 1'b0, 1'b0);
    expect_o(Z2, 1'b0, 1, "t6_zero_after");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Moore-style serial pattern detector; successor to the fixed 10010 detector.
- Pattern, length and overlap mode (REPEAT) are set by parameters.
- Adds a qualifying data_valid input and a saturating match counter with synchronous clear.
- Sits on any 1-bit serial stream; data_out drives downstream event logic, match_cnt feeds status registers.

Parameters:
- PAT_LEN, 5, pattern length in bits; legal range 2..32.
- PATTERN, 5'b10010, target sequence, PAT_LEN bits wide; MSB is the first bit received.
- REPEAT, 1'b1, 1 = overlapping (repeat) detection, 0 = non-overlapping detection.
- CNT_W, 8, match counter width; legal range 1..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  1  serial data bit; sampled only when data_valid=1.
- data_valid  input  1  qualifies data_in for the current cycle.
- cnt_clr  input  1  synchronous clear of match_cnt.
- data_out  output  1  one-cycle match pulse (registered).
- match_cnt  output  CNT_W  saturating count of matches since reset or clear.

Behaviour:
- Reset (rst_n=0, asynchronous): history=0, fill=0, data_out=0, match_cnt=0. All state is held at these values while rst_n is low.
- Internal state:
  - hist[PAT_LEN-1:0] holds the last accepted bits.
  - fill (0..PAT_LEN) counts valid bits held since the last restart.
- Accepted bit (data_valid=1 on a clock edge):
  - hist <= {hist[PAT_LEN-2:0], data_in}.
  - fill <= min(fill+1, PAT_LEN).
- Match condition, evaluated on an accepted bit: (fill+1 >= PAT_LEN) AND ({hist[PAT_LEN-2:0], data_in} == PATTERN).
- data_out timing:
  - Goes high on the edge that accepts the completing bit, so it is visible in the following cycle.
  - Stays high for exactly one cycle, then returns to 0.
  - Latency is 1 cycle from the completing bit.
- data_valid=0: hist and fill hold; data_out=0 that cycle. Gaps in valid never break a partially received pattern.
- REPEAT=1: after a match, fill stays at PAT_LEN. Overlapping matches are detected; back-to-back data_out pulses are legal.
- REPEAT=0: on a match, fill <= 0 (hist may keep shifting). The next match needs PAT_LEN fresh accepted bits, so no bit participates in two matches.
- Fill rule: no match is ever reported before PAT_LEN bits have been accepted since reset or restart, even if hist zeros happen to align with PATTERN (e.g. PATTERN all zeros).
- match_cnt:
  - Increments by 1 on each match, in the same edge that sets data_out.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 without a match: match_cnt <= 0.
  - cnt_clr=1 with a match on the same edge: match_cnt <= 1, so the match is not lost.
  - cnt_clr does not affect hist, fill or data_out.
- Reset mid-pattern discards all partial history; detection restarts from an empty fill.
- Non-power-of-two PAT_LEN and PAT_LEN=32 must work. fill width is clog2(PAT_LEN+1).

Test Plan:
1. Default params, REPEAT=1, data_valid=1, stream 1,0,0,1,0,0,1,0 -> data_out pulses in the cycles after bits 5 and 8; match_cnt=2.
2. Same stream with REPEAT=0 -> single pulse after bit 5; match_cnt=1.
3. REPEAT=1, stream 1,0,0,1,0 with data_valid low for 3 cycles between each bit -> exactly one pulse, one cycle after the edge accepting the final 0; data_out=0 during all gaps.
4. CNT_W=2, REPEAT=1, five overlapping matches -> match_cnt reads 1,2,3,3,3. Then cnt_clr coincident with a 6th match -> match_cnt=1; cnt_clr alone -> 0.
5. Feed 1,0,0,1, drop rst_n mid-cycle for 15 ns, release, then feed 0 -> outputs go 0 immediately (asynchronously) and no pulse follows; a subsequent full 1,0,0,1,0 -> one pulse.
6. PAT_LEN=2, PATTERN=2'b11, stream 1,1,1,1:
   - REPEAT=1 -> 3 pulses, match_cnt=3.
   - REPEAT=0 -> 2 pulses, match_cnt=2.
   - PATTERN=2'b00 after reset with one valid 0 -> no pulse (fill rule).
